// File: rtl/race_sequencer.sv
// Supervisory FSM for a line-follower run: arm on start, soft-start the PWM duty,
// count debounced finish-line laps, stop at the circuit's lap target, fault-stop on line loss.
`timescale 1ns/1ps
module race_sequencer #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int HOLDOFF_CYC  = 50000,
    parameter int RAMP_DIV     = 25000,
    parameter int LOST_CYC     = 500000,
    parameter int CNT_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        senzor_1,
    input  logic        senzor_2,
    input  logic        senzor_3,
    input  logic        senzor_4,
    input  logic        senzor_5,
    input  logic [1:0]  circuit,
    input  logic        start,
    output logic        run_en,
    output logic        brake,
    output logic [11:0] duty_cmd,
    output logic [7:0]  lap_count,
    output logic        lap_pulse,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_RUN      = 3'd2,
        ST_FINISHED = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYC - 1);

    state_t           r_state;
    logic             r_start_q;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_lost_cnt;
    logic [3:0]       r_ramp_d;
    logic             r_hold;
    logic             r_run_en;
    logic             r_brake;
    logic [11:0]      r_duty_cmd;
    logic [7:0]       r_lap_count;
    logic             r_lap_pulse;

    logic             w_finish;
    logic             w_lost;
    logic             w_start_edge;
    logic [7:0]       w_lap_inc;
    logic             w_target_hit;
    logic             w_lap_evt;
    logic             w_holdoff_done;
    logic             w_lost_done;
    logic             w_ramp_step;
    logic [3:0]       w_ramp_next;

    // Sensor pattern decode and start edge detect
    always_comb begin
        w_finish     = senzor_1 & senzor_2 & senzor_4 & senzor_5;
        w_lost       = ~(senzor_1 | senzor_2 | senzor_3 | senzor_4 | senzor_5);
        w_start_edge = start & ~r_start_q;
    end

    // Saturating lap increment
    always_comb begin
        if (r_lap_count == 8'd255) begin
            w_lap_inc = 8'd255;
        end else begin
            w_lap_inc = r_lap_count + 8'd1;
        end
    end

    // Target uses the post-increment count so the stop lands on the counting cycle
    always_comb begin
        case (circuit)
            2'b01:   w_target_hit = (w_lap_inc == 8'd1);
            2'b10:   w_target_hit = (w_lap_inc == 8'd10);
            default: w_target_hit = 1'b0;
        endcase
    end

    // Timer completion events
    always_comb begin
        w_lap_evt      = (r_state == ST_RUN) && !r_hold && w_finish && (r_timer == DEB_LAST);
        w_holdoff_done = r_hold && !w_finish && (r_timer == HOLD_LAST);
        w_lost_done    = w_lost && (r_lost_cnt == LOST_LAST);
        w_ramp_step    = (r_timer == RAMP_LAST);
        w_ramp_next    = r_ramp_d + 4'd1;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_timer     <= '0;
            r_lost_cnt  <= '0;
            r_ramp_d    <= 4'd0;
            r_hold      <= 1'b0;
            r_run_en    <= 1'b0;
            r_brake     <= 1'b1;
            r_duty_cmd  <= 12'h000;
            r_lap_count <= 8'd0;
            r_lap_pulse <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_lap_pulse <= 1'b0;
            if ((circuit == 2'b00) && (r_state != ST_IDLE)) begin
                r_state     <= ST_IDLE;
                r_timer     <= '0;
                r_lost_cnt  <= '0;
                r_ramp_d    <= 4'd0;
                r_hold      <= 1'b0;
                r_run_en    <= 1'b0;
                r_brake     <= 1'b1;
                r_duty_cmd  <= 12'h000;
                r_lap_count <= 8'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_edge && (circuit != 2'b00)) begin
                            r_state     <= ST_RAMP;
                            r_lap_count <= 8'd0;
                            r_ramp_d    <= 4'd1;
                            r_timer     <= '0;
                            r_run_en    <= 1'b1;
                            r_brake     <= 1'b0;
                            r_duty_cmd  <= 12'h100;
                        end else begin
                            r_run_en   <= 1'b0;
                            r_brake    <= 1'b1;
                            r_duty_cmd <= 12'h000;
                        end
                    end
                    ST_RAMP: begin
                        if (w_ramp_step) begin
                            r_timer <= '0;
                            if (w_ramp_next == 4'd9) begin
                                r_state    <= ST_RUN;
                                r_ramp_d   <= 4'd9;
                                r_duty_cmd <= 12'h999;
                                r_hold     <= 1'b0;
                                r_lost_cnt <= '0;
                            end else begin
                                r_ramp_d   <= w_ramp_next;
                                r_duty_cmd <= {w_ramp_next, 8'h00};
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_lap_evt) begin
                            r_lap_count <= w_lap_inc;
                            r_lap_pulse <= 1'b1;
                            r_hold      <= 1'b1;
                            r_timer     <= '0;
                            r_lost_cnt  <= '0;
                            if (w_target_hit) begin
                                r_state    <= ST_FINISHED;
                                r_run_en   <= 1'b0;
                                r_brake    <= 1'b1;
                                r_duty_cmd <= 12'h000;
                            end
                        end else if (w_lost_done) begin
                            r_state    <= ST_FAULT;
                            r_timer    <= '0;
                            r_lost_cnt <= '0;
                            r_hold     <= 1'b0;
                            r_run_en   <= 1'b0;
                            r_brake    <= 1'b1;
                            r_duty_cmd <= 12'h000;
                        end else begin
                            r_lost_cnt <= w_lost ? (r_lost_cnt + 1'b1) : '0;
                            if (!r_hold) begin
                                r_timer <= w_finish ? (r_timer + 1'b1) : '0;
                            end else if (w_holdoff_done) begin
                                r_hold  <= 1'b0;
                                r_timer <= '0;
                            end else begin
                                r_timer <= w_finish ? '0 : (r_timer + 1'b1);
                            end
                        end
                    end
                    ST_FINISHED, ST_FAULT: begin
                        if (w_start_edge) begin
                            r_state <= ST_IDLE;
                        end
                        r_timer    <= '0;
                        r_lost_cnt <= '0;
                        r_run_en   <= 1'b0;
                        r_brake    <= 1'b1;
                        r_duty_cmd <= 12'h000;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_timer    <= '0;
                        r_lost_cnt <= '0;
                        r_hold     <= 1'b0;
                        r_run_en   <= 1'b0;
                        r_brake    <= 1'b1;
                        r_duty_cmd <= 12'h000;
                    end
                endcase
            end
        end
    end

    assign run_en    = r_run_en;
    assign brake     = r_brake;
    assign duty_cmd  = r_duty_cmd;
    assign lap_count = r_lap_count;
    assign lap_pulse = r_lap_pulse;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed run scenarios plus random sensor/control traffic,
// every cycle compared against a run-length based behavioural model.
`timescale 1ns/1ps
module tb_race_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 4;
    localparam int RDIV = 2;
    localparam int LOST = 20;

    localparam logic [4:0] P_FIN  = 5'b11011;
    localparam logic [4:0] P_LINE = 5'b00100;
    localparam logic [4:0] P_LOST = 5'b00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  sens = P_LINE;
    logic [1:0]  circuit = 2'b00;
    logic        start = 1'b0;
    logic        run_en, brake, lap_pulse;
    logic [11:0] duty_cmd;
    logic [7:0]  lap_count;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 ramp, 2 run, 3 finished, 4 fault
    int m_mode = 0, m_lap = 0, m_pulse = 0, m_start_prev = 0;
    int m_ramp_cycles = 0, m_fin_run = 0, m_gap_run = 0, m_lost_run = 0, m_armed = 1;

    race_sequencer #(.DEBOUNCE_CYC(DEB), .HOLDOFF_CYC(HOLD), .RAMP_DIV(RDIV),
                     .LOST_CYC(LOST), .CNT_W(20)) dut (
        .clk(clk), .reset(reset),
        .senzor_1(sens[0]), .senzor_2(sens[1]), .senzor_3(sens[2]),
        .senzor_4(sens[3]), .senzor_5(sens[4]),
        .circuit(circuit), .start(start),
        .run_en(run_en), .brake(brake), .duty_cmd(duty_cmd),
        .lap_count(lap_count), .lap_pulse(lap_pulse), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic enter_run();
        m_mode = 2; m_armed = 1; m_fin_run = 0; m_gap_run = 0; m_lost_run = 0;
    endtask

    task automatic model_step();
        int  edge_s;
        bit  fin, lst;
        edge_s = (start && !m_start_prev) ? 1 : 0;
        m_start_prev = start ? 1 : 0;
        m_pulse = 0;
        fin = sens[0] & sens[1] & sens[3] & sens[4];
        lst = (sens == 5'b00000);
        if (reset) begin
            m_mode = 0; m_lap = 0; m_start_prev = 0; m_ramp_cycles = 0;
            m_fin_run = 0; m_gap_run = 0; m_lost_run = 0; m_armed = 1;
        end else if (circuit == 2'b00 && m_mode != 0) begin
            m_mode = 0; m_lap = 0;
        end else if (m_mode == 0) begin
            if (edge_s == 1 && circuit != 2'b00) begin
                m_mode = 1; m_lap = 0; m_ramp_cycles = 0;
            end
        end else if (m_mode == 1) begin
            m_ramp_cycles++;
            if (m_ramp_cycles == 8 * RDIV) enter_run();
        end else if (m_mode == 2) begin
            if (m_armed == 1) begin
                m_fin_run = fin ? m_fin_run + 1 : 0;
                if (m_fin_run == DEB) begin
                    m_lap = (m_lap >= 255) ? 255 : m_lap + 1;
                    m_pulse = 1; m_armed = 0; m_fin_run = 0; m_gap_run = 0;
                    if ((circuit == 2'b01 && m_lap == 1) || (circuit == 2'b10 && m_lap == 10))
                        m_mode = 3;
                end
            end else begin
                m_gap_run = fin ? 0 : m_gap_run + 1;
                if (m_gap_run == HOLD) begin
                    m_armed = 1; m_gap_run = 0; m_fin_run = 0;
                end
            end
            if (m_mode == 2) begin
                m_lost_run = lst ? m_lost_run + 1 : 0;
                if (m_lost_run == LOST && m_pulse == 0) m_mode = 4;
            end
        end else begin
            if (edge_s == 1) m_mode = 0;
        end
    endtask

    task automatic tick();
        int exp_duty;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_mode == 1)      exp_duty = 100 * (1 + m_ramp_cycles / RDIV);
        else if (m_mode == 2) exp_duty = 999;
        else                  exp_duty = 0;
        chk("state",     32'(state_dbg), 32'(m_mode));
        chk("run_en",    32'(run_en),    32'(m_mode == 1 || m_mode == 2));
        chk("brake",     32'(brake),     32'(!(m_mode == 1 || m_mode == 2)));
        chk("duty",      32'(duty_cmd),  32'(to_bcd(exp_duty)));
        chk("lap_count", 32'(lap_count), 32'(m_lap));
        chk("lap_pulse", 32'(lap_pulse), 32'(m_pulse));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_pulse();
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(1);
    endtask

    task automatic lap(input int fin_len, input int gap_len);
        sens = P_FIN;  cyc(fin_len);
        sens = P_LINE; cyc(gap_len);
    endtask

    initial begin
        // reset values
        cyc(2);
        chk("rst_brake", 32'(brake), 32'd1);
        chk("rst_duty",  32'(duty_cmd), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        cyc(2);

        // straight circuit: ramp then one lap
        circuit = 2'b01;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("ramp_first", 32'(duty_cmd), 32'h100);
        cyc(15);
        chk("ramp_last", 32'(duty_cmd), 32'h800);
        cyc(1);
        chk("run_duty", 32'(duty_cmd), 32'h999);
        cyc(2);
        sens = P_FIN; cyc(3);
        chk("no_lap_3", 32'(lap_count), 32'd0);
        cyc(1);
        chk("lap1_pulse", 32'(lap_pulse), 32'd1);
        chk("lap1_fin", 32'(state_dbg), 32'd3);
        sens = P_LINE; cyc(2);
        chk("fin_brake", 32'(brake), 32'd1);

        // curves circuit: short finish, short gap, ten laps
        start_pulse();
        chk("back_idle_lap", 32'(lap_count), 32'd1);
        circuit = 2'b10;
        start_pulse(); cyc(18);
        lap(3, 4);
        chk("short_fin", 32'(lap_count), 32'd0);
        lap(4, 3);
        lap(4, 4);
        chk("gap_block", 32'(lap_count), 32'd1);
        for (int i = 0; i < 9; i++) lap(4, 4);
        chk("ten_laps", 32'(lap_count), 32'd10);
        chk("ten_fin", 32'(state_dbg), 32'd3);

        // endurance: saturation
        start_pulse();
        circuit = 2'b11;
        start_pulse(); cyc(18);
        for (int i = 0; i < 260; i++) lap(4, 4);
        chk("sat_lap", 32'(lap_count), 32'd255);
        chk("sat_run", 32'(state_dbg), 32'd2);

        // line lost
        sens = P_LOST; cyc(19);
        sens = P_LINE; cyc(2);
        chk("lost19_run", 32'(state_dbg), 32'd2);
        sens = P_LOST; cyc(20);
        chk("lost_fault", 32'(state_dbg), 32'd4);
        chk("fault_duty", 32'(duty_cmd), 32'd0);
        sens = P_LINE; cyc(2);
        start_pulse();

        // circuit cleared mid-ramp / mid-run, ignored start, reset in run
        circuit = 2'b01; start_pulse(); cyc(3);
        circuit = 2'b00; cyc(1);
        chk("clr_ramp", 32'(state_dbg), 32'd0);
        start_pulse();
        chk("ign_start", 32'(state_dbg), 32'd0);
        circuit = 2'b11; start_pulse(); cyc(18);
        for (int i = 0; i < 3; i++) lap(4, 4);
        chk("three_laps", 32'(lap_count), 32'd3);
        circuit = 2'b00; cyc(1);
        chk("clr_run_lap", 32'(lap_count), 32'd0);
        circuit = 2'b11; start_pulse(); cyc(18);
        lap(4, 4); lap(4, 4);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("rst_run_lap", 32'(lap_count), 32'd0);
        cyc(1);

        // random traffic
        for (int seg = 0; seg < 600; seg++) begin
            int kind;
            int r;
            kind = int'($urandom_range(0, 9));
            if (kind <= 3) begin
                sens = P_FIN; cyc(int'($urandom_range(1, 6)));
            end else if (kind <= 6) begin
                sens = P_LINE; cyc(int'($urandom_range(1, 6)));
            end else if (kind == 7) begin
                sens = P_LOST; cyc(int'($urandom_range(1, 24)));
            end else if (kind == 8) begin
                sens = 5'($urandom_range(0, 31)); cyc(int'($urandom_range(1, 3)));
            end else begin
                r = int'($urandom_range(0, 19));
                if (r <= 5) start_pulse();
                else if (r <= 17) begin
                    circuit = 2'($urandom_range(0, 3)); cyc(1);
                end else begin
                    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
